// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO write arbiter: FSM state encoding,
// gap-counter width and default build parameters.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int GAP_CNT_W  = 4;
  localparam int DEF_N_REQ  = 3;
  localparam int DEF_DATA_W = 8;

endpackage : gpio_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin winner search: scans from last_gnt_i+1 upward and wraps to 0,
// returning the first requester found as both one-hot and index.
module rr_pick
  import gpio_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_gnt_i,
  output logic [N_REQ-1:0] winner_oh_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] oh_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Rotating priority scan; the previous winner is visited last.
  always_comb begin
    oh_s    = '0;
    idx_s   = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((int'(last_gnt_i) + k) % N_REQ);
      if (!found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        idx_s         = cand_s;
        oh_s[cand_s]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign winner_oh_o  = oh_s;
  assign winner_idx_o = idx_s;
  assign valid_o      = found_s;

endmodule : rr_pick

// File: rtl/gpio_wr_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto one GPIO register
// write port, with a programmable idle gap after every grant.
module gpio_wr_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYCLES = 2,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic                    we_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    busy,
  output logic [IDX_W-1:0]        last_gnt
);

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]     LAST_INIT = IDX_W'(N_REQ - 1);

  arb_state_e             state_q;
  logic [GAP_CNT_W-1:0]   gap_cnt_q;
  logic [N_REQ-1:0]       ack_q;
  logic                   we_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   busy_q;
  logic [IDX_W-1:0]       last_gnt_q;

  logic [N_REQ-1:0]       pick_oh_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_valid_s;
  logic [DATA_W-1:0]      wdata_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .last_gnt_i   (last_gnt_q),
    .winner_oh_o  (pick_oh_s),
    .winner_idx_o (pick_idx_s),
    .valid_o      (pick_valid_s)
  );

  // One-hot data mux selecting the winner's write data for capture.
  always_comb begin
    wdata_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wdata_d = wdata_d | ({DATA_W{pick_oh_s[i]}} & wdata[i*DATA_W +: DATA_W]);
    end
  end

  // FSM with registered outputs; wdata_q doubles as the capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      last_gnt_q <= LAST_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            state_q    <= GRANT;
            we_q       <= 1'b1;
            ack_q      <= pick_oh_s;
            wdata_q    <= wdata_d;
            last_gnt_q <= pick_idx_s;
            busy_q     <= 1'b1;
          end else begin
            we_q   <= 1'b0;
            ack_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        GRANT: begin
          we_q  <= 1'b0;
          ack_q <= '0;
          if (GAP_CYCLES > 0) begin
            state_q   <= GAP;
            gap_cnt_q <= GAP_LOAD;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GAP: begin
          we_q  <= 1'b0;
          ack_q <= '0;
          if (gap_cnt_q <= 4'd1) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          gap_cnt_q <= '0;
          we_q      <= 1'b0;
          ack_q     <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign we_o     = we_q;
  assign wdata_o  = wdata_q;
  assign busy     = busy_q;
  assign last_gnt = last_gnt_q;

endmodule : gpio_wr_arbiter

// File: tb/tb_gpio_wr_arbiter.sv
// Directed bench for gpio_wr_arbiter: a GAP_CYCLES=2 and a GAP_CYCLES=0 build
// share stimulus and are checked every cycle against a schedule-based model.
module tb_gpio_wr_arbiter;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;

  logic [N-1:0] ack_a, ack_b;
  logic         we_a, we_b;
  logic [W-1:0] wd_a, wd_b;
  logic         busy_a, busy_b;
  logic [1:0]   lg_a, lg_b;

  always #5 clk = ~clk;

  gpio_wr_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack_a),
    .we_o(we_a), .wdata_o(wd_a), .busy(busy_a), .last_gnt(lg_a)
  );

  gpio_wr_arbiter #(.N_REQ(N), .DATA_W(W), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack_b),
    .we_o(we_b), .wdata_o(wd_b), .busy(busy_b), .last_gnt(lg_b)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each build is either free (may sample req) from edge m_next on, or
  // busy for a fixed 2+gap edges after a grant.
  int           edge_n = 0;
  int           m_gap [2] = '{2, 0};
  int           m_last [2];
  int           m_next [2];
  int           m_busy_until [2];
  logic         m_we [2];
  logic [N-1:0] m_ack [2];
  logic [W-1:0] m_data [2];
  logic         m_busy [2];
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    int w;
    int c;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_last[i]       = N - 1;
        m_next[i]       = edge_n + 1;
        m_busy_until[i] = 0;
        m_we[i]         = 1'b0;
        m_ack[i]        = '0;
        m_data[i]       = '0;
      end else if (edge_n >= m_next[i] && req != 3'b000) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_last[i] + k) % N;
          if (w < 0 && ((req >> c) & 3'b001) != 3'b000) w = c;
        end
        m_we[i]         = 1'b1;
        m_ack[i]        = 3'b001 << w;
        m_data[i]       = W'(wdata >> (w * W));
        m_last[i]       = w;
        m_next[i]       = edge_n + 2 + m_gap[i];
        m_busy_until[i] = edge_n + 1 + m_gap[i];
      end else begin
        m_we[i]  = 1'b0;
        m_ack[i] = '0;
      end
      m_busy[i] = (edge_n < m_busy_until[i]);
    end
    if (rst) m_valid = 1'b1;
    edge_n++;
  end

  // Per-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a.we",       32'(we_a),   32'(m_we[0]));
      chk("a.ack",      32'(ack_a),  32'(m_ack[0]));
      chk("a.wdata_o",  32'(wd_a),   32'(m_data[0]));
      chk("a.busy",     32'(busy_a), 32'(m_busy[0]));
      chk("a.last_gnt", 32'(lg_a),   32'(m_last[0]));
      chk("b.we",       32'(we_b),   32'(m_we[1]));
      chk("b.ack",      32'(ack_b),  32'(m_ack[1]));
      chk("b.wdata_o",  32'(wd_b),   32'(m_data[1]));
      chk("b.busy",     32'(busy_b), 32'(m_busy[1]));
      chk("b.last_gnt", 32'(lg_b),   32'(m_last[1]));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wcyc[$];
    logic [W-1:0] wdat[$];
    int busy_cnt;

    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_we",    32'(we_a),   32'h0);
    chk("rst_ack",   32'(ack_a),  32'h0);
    chk("rst_busy",  32'(busy_a), 32'h0);
    chk("rst_wdata", 32'(wd_a),   32'h0);
    chk("rst_last",  32'(lg_a),   32'h2);
    rst = 1'b0;

    // Single request from requester 1.
    @(negedge clk);
    req   = 3'b010;
    wdata = 24'h00A500;
    @(negedge clk);
    chk("s1_we",    32'(we_a),  32'h1);
    chk("s1_wdata", 32'(wd_a),  32'hA5);
    chk("s1_ack",   32'(ack_a), 32'h2);
    chk("s1_last",  32'(lg_a),  32'h1);
    chk("s1_model_data", 32'(m_data[0]), 32'hA5);
    req      = 3'b000;
    busy_cnt = busy_a ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      busy_cnt += busy_a ? 1 : 0;
    end
    chk("s1_busy_cycles", 32'(busy_cnt), 32'd3);

    // All requests held: strict rotation, 4-cycle spacing.
    do_reset();
    req   = 3'b111;
    wdata = 24'h332211;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (we_a) begin
        wcyc.push_back(c);
        wdat.push_back(wd_a);
      end
    end
    chk("s2_count", 32'(wcyc.size()), 32'd4);
    if (wcyc.size() >= 4) begin
      chk("s2_d0", 32'(wdat[0]), 32'h11);
      chk("s2_d1", 32'(wdat[1]), 32'h22);
      chk("s2_d2", 32'(wdat[2]), 32'h33);
      chk("s2_d3", 32'(wdat[3]), 32'h11);
      for (int k = 1; k < 4; k++) chk("s2_spacing", 32'(wcyc[k] - wcyc[k-1]), 32'd4);
    end

    // Request arriving during GAP is ignored until IDLE.
    req = 3'b000;
    do_reset();
    wdata = 24'hC3005A;
    req   = 3'b001;
    @(negedge clk);
    chk("s3_grant0", 32'(ack_a), 32'h1);
    req = 3'b000;
    @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    chk("s3_gap_we", 32'(we_a), 32'h0);
    @(negedge clk);
    chk("s3_idle_we",   32'(we_a),   32'h0);
    chk("s3_idle_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    chk("s3_grant2_ack",   32'(ack_a), 32'h4);
    chk("s3_grant2_wdata", 32'(wd_a),  32'hC3);
    req = 3'b000;
    repeat (4) @(negedge clk);

    // Drop req and change wdata right after capture.
    wdata = 24'h00007E;
    req   = 3'b001;
    @(posedge clk);
    #1;
    req   = 3'b000;
    wdata = 24'h0000FF;
    @(negedge clk);
    chk("s4_we",    32'(we_a),  32'h1);
    chk("s4_ack",   32'(ack_a), 32'h1);
    chk("s4_wdata", 32'(wd_a),  32'h7E);
    repeat (4) @(negedge clk);

    // Reset in GAP aborts; requester 0 wins first afterwards.
    do_reset();
    wdata = 24'h332211;
    req   = 3'b111;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_we",    32'(we_a),   32'h0);
    chk("s5_ack",   32'(ack_a),  32'h0);
    chk("s5_busy",  32'(busy_a), 32'h0);
    chk("s5_wdata", 32'(wd_a),   32'h0);
    chk("s5_last",  32'(lg_a),   32'h2);
    rst = 1'b0;
    @(negedge clk);
    chk("s5_first_ack",   32'(ack_a), 32'h1);
    chk("s5_first_last",  32'(lg_a),  32'h0);
    chk("s5_first_wdata", 32'(wd_a),  32'h11);

    // Zero-gap build: write every second cycle, never overlapping acks.
    do_reset();
    req = 3'b111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("s6_we_b", 32'(we_b), (c % 2 == 0) ? 32'h1 : 32'h0);
      chk("s6_onehot_b", 32'($countones(ack_b)), (c % 2 == 0) ? 32'h1 : 32'h0);
    end
    req = 3'b000;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_gpio_wr_arbiter

// File: doc/gpio_wr_arbiter.md
GPIO_WR_ARBITER -- requirements
Module: gpio_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters, range 2..8.
REQ-002 Parameter DATA_W, default 8: write-data width, matching the GPIO register.
REQ-003 Parameter GAP_CYCLES, default 2: idle cycles enforced after every grant, range 0..15.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req  input  N_REQ  per-requester write request, level.
REQ-007 Port wdata  input  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
REQ-008 Port ack  output  N_REQ  one-cycle pulse: requester i write performed.
REQ-009 Port we_o  output  1  write enable to the GPIO register, one-cycle pulse.
REQ-010 Port wdata_o  output  DATA_W  data to the GPIO register, valid when we_o=1.
REQ-011 Port busy  output  1  high in GRANT or GAP state.
REQ-012 Port last_gnt  output  clog2(N_REQ)  index of the most recently granted requester.

Function
REQ-013 FSM states: IDLE, GRANT, GAP; all outputs are registered.
REQ-014 IDLE with any req bit set: pick the winner, capture its wdata, go to GRANT next cycle.
REQ-015 IDLE with req=0: stay in IDLE.
REQ-016 GRANT lasts exactly one cycle: we_o=1, wdata_o=captured data, ack[winner]=1, all other ack bits 0.
REQ-017 GRANT -> GAP when GAP_CYCLES>0, otherwise GRANT -> IDLE.
REQ-018 GAP holds for exactly GAP_CYCLES cycles, tracked by a 4-bit down-counter, then goes to IDLE.
REQ-019 Latency: req sampled high in IDLE at edge N -> we_o/ack high in cycle N+1.
REQ-020 Maximum throughput: one write per 2+GAP_CYCLES cycles.
REQ-021 Arbitration is round-robin; search starts at index last_gnt+1 and wraps from N_REQ-1 to 0.
REQ-022 last_gnt updates on entry to GRANT.
REQ-023 Requests are not sampled in GRANT or GAP; req changes there have no effect.
REQ-024 A requester holds req and wdata until ack; the arbiter uses only the data captured in IDLE.
REQ-025 A req dropped after capture still completes; its ack is still issued.
REQ-026 A requester that keeps req high after ack is re-arbitrated in the next IDLE with lowest priority.
REQ-027 All requests asserted simultaneously: grants go in strict rotation, e.g. 0,1,2,0 for N_REQ=3 from reset.
REQ-028 we_o and at most one ack bit are high together; no ack without we_o.
REQ-029 wdata_o holds its last value outside GRANT; its reset value is 0.

Reset
REQ-030 rst=1 at an edge forces: state IDLE, we_o=0, ack=0, busy=0, wdata_o=0, gap counter=0, last_gnt=N_REQ-1 (requester 0 has first priority).
REQ-031 Reset during GRANT or GAP aborts the operation; no ack is issued for the captured request.
REQ-032 Arbitration resumes in the first cycle after rst deasserts.

Structure
REQ-033 Shared package gpio_arb_pkg holds the state enum (IDLE, GRANT, GAP), the GAP counter width (4), and the default N_REQ/DATA_W values.
REQ-034 A single combinational sub-module, rr_pick (inputs req and last_gnt; outputs one-hot winner and index), performs the rotation search.
REQ-035 The FSM, capture register, gap counter and output registers reside in gpio_wr_arbiter.
REQ-036 Target size: 120-400 lines of RTL in total.

Verification
REQ-037 Single request: after reset, req=3'b010, wdata[15:8]=8'hA5 -> cycle+1: we_o=1, wdata_o=8'hA5, ack=3'b010, last_gnt=1; busy high 3 cycles (GAP_CYCLES=2).
REQ-038 All requests held: req=3'b111 with data 11/22/33 -> writes 8'h11, 8'h22, 8'h33, 8'h11, spaced exactly 4 cycles apart.
REQ-039 Request in GAP: req[2] asserted during GAP -> ignored until IDLE; granted on the cycle after GAP ends.
REQ-040 Drop after capture: req[0] high for one IDLE cycle only -> ack[0] and we_o are still pulsed with the captured data.
REQ-041 Reset in GAP: rst pulsed in GAP -> all outputs 0 the next cycle; with req=3'b111, requester 0 is granted first afterwards.
REQ-042 GAP_CYCLES=0 build with req continuously high -> we_o pulses every 2nd cycle; ack never overlaps for different requesters.
